fb_pixel_writer: RTL and testbench
==================================

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins one frame; sampled only in IDLE.
REQ-004 SHALL have port photo_size, input, 2 bits: 01=128x128, 10=256x256, 11=512x512, 00 treated as 10; latched at start.
REQ-005 SHALL have port fb_base, input, 20 bits: framebuffer base address; latched at start.
REQ-006 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, 24 bits): source pixel stream, RGB with 8 bits per channel, R in [23:16].
REQ-007 SHALL have ports im_a (output, 20 bits), im_d (output, 24 bits) and im_wen_n (output, 1 bit): image-memory write port, active-low write enable.
REQ-008 SHALL have output busy, 1 bit: high from the cycle after start until done.
REQ-009 SHALL have output done, 1 bit: one-cycle pulse when the last framebuffer write is issued.

Function
REQ-010 SHALL implement states IDLE, ACCUM, WRITE and DONE.
REQ-011 SHALL, on start in IDLE, latch photo_size and fb_base, clear all counters and enter ACCUM next cycle.
REQ-012 SHALL drive in_ready=1 only in ACCUM; a beat transfers when in_valid&&in_ready.
REQ-013 SHALL, in size 10, leave ACCUM for WRITE after each beat and issue one write: im_d=pixel, im_a=fb_base+{row[7:0],col[7:0]}.
REQ-014 SHALL, in size 11, take 4 beats in 2x2 block order (TL, TR, BL, BR), sum each channel into 10 bits, then issue one write with channel=sum>>2 (rounding per REQ-024).
REQ-015 SHALL, in size 01, take 1 beat, then issue 4 consecutive writes at offsets (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1), where (r,c) is the 128-raster source coordinate.
REQ-016 SHALL hold im_wen_n=0 for exactly one cycle per write, with im_a and im_d valid in that cycle.
REQ-017 SHALL produce exactly 65536 writes per frame for every size; output row/col raster order for sizes 10 and 11.
REQ-018 SHALL enter DONE after the 65536th write, pulse done=1 for one cycle, deassert busy, and return to IDLE.
REQ-019 SHALL compute address addition modulo 2^20; fb_base+offset overflow wraps silently.
REQ-020 SHALL ignore start while busy; in_valid in IDLE/WRITE/DONE SHALL be ignored and never consumed.
REQ-021 SHALL allow in_valid to stall indefinitely mid-block; accumulator and counters hold their values.

Reset
REQ-022 SHALL, on reset assertion at any time including mid-frame, asynchronously force IDLE, im_wen_n=1, im_a=0, im_d=0, in_ready=0, busy=0, done=0, and clear accumulators and counters; partial frames are abandoned.
REQ-023 SHALL accept start on the first clock edge after reset deasserts.

Configuration
REQ-024 SHALL, with macro FB_AVG_ROUND_EN defined, compute channel=(sum+2)>>2 (round half up, saturating at 255); without it, channel=sum>>2 (truncate).

Structure
REQ-025 SHALL place photo_size encodings, FB_DIM=256, FB_PIXELS=65536 and the state encodings in shared package dpa_pkg.
REQ-026 SHALL implement the 4-beat per-channel accumulate/divide as sub-module pix_avg4 (clear, add, 24-bit result).

Verification
REQ-027 Size 10, fb_base=0x10000, 65536 beats of pixel index -> write k at 0x10000+k with im_d=k[23:0], done after last write.
REQ-028 Size 11, block beats 0x0A0A0A, 0x0B0B0B, 0x0C0C0C, 0x0D0D0D -> write 0x0C0C0C with FB_AVG_ROUND_EN (46+2>>2=12), 0x0B0B0B without it.
REQ-029 Size 01, first beat 0xFF0000 -> writes at fb_base+0x0000, 0x0001, 0x0100, 0x0101, all with data 0xFF0000.
REQ-030 fb_base=0xFFFF0, size 10 -> write 16 lands at address 0x00000 (wrap).
REQ-031 Reset pulsed after 3 of 4 size-11 beats -> all outputs at reset values; a new start gives the first write at fb_base+0 and a clean average.
REQ-032 start pulsed mid-frame plus in_valid held high during WRITE -> no restart, one beat consumed per ACCUM cycle, and exactly 65536 writes in total.

Source files
------------

// File: rtl/dpa_pkg.sv
// Shared definitions for the framebuffer pixel writer.
//   - photo_size encodings (00 decodes as 256x256)
//   - framebuffer geometry (FB_DIM, FB_PIXELS)
//   - writer FSM state encodings
//   - fb_offset(): maps a write index to the 16-bit framebuffer offset {row,col}
package dpa_pkg;

  typedef enum logic [1:0] {
    SZ_DEFAULT = 2'b00,
    SZ_128     = 2'b01,
    SZ_256     = 2'b10,
    SZ_512     = 2'b11
  } photo_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int unsigned FB_DIM    = 256;
  localparam int unsigned FB_PIXELS = FB_DIM * FB_DIM;

  // For 256x256 and 512x512 the writes come out in raster order, so the write
  // index is the offset. For 128x128 each source pixel s=(r,c) expands to four
  // writes idx = {s, dy, dx}, landing at row {r,dy}, col {c,dx}.
  function automatic logic [15:0] fb_offset(input photo_size_e size,
                                            input logic [15:0] idx);
    if (size == SZ_128) return {idx[15:9], idx[1], idx[8:2], idx[0]};
    else                return idx;
  endfunction

endpackage

// File: rtl/pix_avg4.sv
// Four-beat per-channel averager for 512x512 -> 256x256 downscaling.
// Each 8-bit channel is accumulated into a 10-bit sum. result_o is the divided
// sum including the beat currently presented on pix_i when add_i is high, so
// the caller can register the average on the same edge as the fourth beat.
// clear_i has priority over add_i for the stored accumulator.
// Build option: FB_AVG_ROUND_EN selects (sum+2)>>2 saturating at 255;
// otherwise the divide truncates (sum>>2).
// Ports:
//   clk, reset   clock, async active-high reset
//   clear_i      zero the accumulator on the next edge
//   add_i        accumulate pix_i on the next edge
//   pix_i[23:0]  RGB pixel, R in [23:16]
//   result_o     per-channel average of the accumulated (plus current) beats
module pix_avg4
  import dpa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        add_i,
  input  logic [23:0] pix_i,
  output logic [23:0] result_o
);

  logic [2:0][9:0] acc_q;
  logic [2:0][9:0] acc_d;
  logic [2:0][9:0] sum;
`ifdef FB_AVG_ROUND_EN
  logic [2:0][10:0] rnd;
`endif

  always_comb begin
    sum      = '0;
    acc_d    = '0;
    result_o = '0;
`ifdef FB_AVG_ROUND_EN
    rnd      = '0;
`endif
    for (int ch = 0; ch < 3; ch++) begin
      sum[ch]   = acc_q[ch] + (add_i ? {2'b00, pix_i[ch*8 +: 8]} : 10'd0);
      acc_d[ch] = clear_i ? 10'd0 : sum[ch];
`ifdef FB_AVG_ROUND_EN
      rnd[ch]   = {1'b0, sum[ch]} + 11'd2;
      result_o[ch*8 +: 8] = rnd[ch][10] ? 8'hFF : rnd[ch][9:2];
`else
      result_o[ch*8 +: 8] = sum[ch][9:2];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: consumes an RGB pixel stream and writes a 256x256
// frame into image memory, scaling 128x128 sources up (pixel replication) and
// 512x512 sources down (2x2 averaging, see pix_avg4).
// Build option: FB_AVG_ROUND_EN enables round-half-up in the 2x2 average.
// FRAME_WRITES is the number of writes after which the frame completes; it
// defaults to the full frame and is only lowered for short simulations.
// Ports:
//   clk, reset          clock, async active-high reset
//   start               frame start pulse, sampled in IDLE only
//   photo_size[1:0]     01=128, 10=256, 11=512, 00=256; latched at start
//   fb_base[19:0]       framebuffer base address; latched at start
//   in_valid/in_ready   pixel stream handshake, in_data[23:0] RGB
//   im_a/im_d/im_wen_n  image-memory write port, write enable active low
//   busy                frame in progress
//   done                one-cycle pulse after the final write
module fb_pixel_writer
  import dpa_pkg::*;
#(
  parameter int unsigned FRAME_WRITES = FB_PIXELS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  photo_size,
  input  logic [19:0] fb_base,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  output logic [19:0] im_a,
  output logic [23:0] im_d,
  output logic        im_wen_n,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_WRITES - 1);

  state_e      state_q;
  photo_size_e size_q;
  logic [19:0] base_q;
  logic [15:0] wr_idx_q;
  logic [1:0]  beat_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        wen_n_q;
  logic [19:0] im_a_q;
  logic [23:0] im_d_q;

  logic        beat_fire;
  logic        blk_last;
  logic        avg_add;
  logic        avg_clear;
  logic [23:0] avg_pix;
  logic [15:0] wr_idx_nxt;
  logic [19:0] addr_cur;
  logic [19:0] addr_nxt;

  assign beat_fire  = in_valid && in_ready_q;
  assign blk_last   = (beat_q == 2'd3);
  assign avg_add    = beat_fire && (size_q == SZ_512);
  // Clear at frame start and on the fourth beat (the average is taken from
  // the combinational sum on that same edge).
  assign avg_clear  = ((state_q == ST_IDLE) && start) || (avg_add && blk_last);
  assign wr_idx_nxt = wr_idx_q + 16'd1;
  // 20-bit add wraps modulo 2^20.
  assign addr_cur   = base_q + {4'b0000, fb_offset(size_q, wr_idx_q)};
  assign addr_nxt   = base_q + {4'b0000, fb_offset(size_q, wr_idx_nxt)};

  pix_avg4 u_avg (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (avg_clear),
    .add_i    (avg_add),
    .pix_i    (in_data),
    .result_o (avg_pix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      size_q     <= SZ_256;
      base_q     <= '0;
      wr_idx_q   <= '0;
      beat_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wen_n_q    <= 1'b1;
      im_a_q     <= '0;
      im_d_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            size_q     <= (photo_size == SZ_DEFAULT) ? SZ_256 : photo_size_e'(photo_size);
            base_q     <= fb_base;
            wr_idx_q   <= '0;
            beat_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat_fire) begin
            if ((size_q == SZ_512) && !blk_last) begin
              beat_q <= beat_q + 2'd1;
            end else begin
              beat_q     <= '0;
              im_d_q     <= (size_q == SZ_512) ? avg_pix : in_data;
              im_a_q     <= addr_cur;
              wen_n_q    <= 1'b0;
              in_ready_q <= 1'b0;
              state_q    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          wr_idx_q <= wr_idx_nxt;
          // 128x128 replicates each pixel into four back-to-back writes.
          if ((size_q == SZ_128) && (wr_idx_q[1:0] != 2'b11)) begin
            im_a_q <= addr_nxt;
          end else begin
            wen_n_q <= 1'b1;
            if (wr_idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ST_ACCUM;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign im_wen_n = wen_n_q;
  assign im_a     = im_a_q;
  assign im_d     = im_d_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
`timescale 1ns/1ps
module tb_fb_pixel_writer;

  localparam int FW = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  photo_size = 2'b00;
  logic [19:0] fb_base = '0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready;
  logic [19:0] im_a;
  logic [23:0] im_d;
  logic        im_wen_n;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit hung = 1'b0;

  logic [19:0] got_a[$];
  logic [23:0] got_d[$];
  logic [19:0] exp_a[$];
  logic [23:0] exp_d[$];

  always #5 clk = ~clk;

  fb_pixel_writer #(.FRAME_WRITES(FW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .photo_size (photo_size),
    .fb_base    (fb_base),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .im_a       (im_a),
    .im_d       (im_d),
    .im_wen_n   (im_wen_n),
    .busy       (busy),
    .done       (done)
  );

  // Write-port and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (im_wen_n === 1'b0) begin
        got_a.push_back(im_a);
        got_d.push_back(im_d);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: framebuffer address of write j for a given effective size.
  function automatic logic [19:0] ref_addr(input int size, input logic [19:0] base, input int j);
    int off, s, r, c;
    if (size == 1) begin
      s = j / 4;
      r = s / 128;
      c = s % 128;
      off = (2 * r + (j % 4) / 2) * 256 + 2 * c + (j % 2);
    end else begin
      off = j;
    end
    return base + 20'(off);
  endfunction

  function automatic logic [23:0] ref_avg(input logic [23:0] p0, input logic [23:0] p1,
                                          input logic [23:0] p2, input logic [23:0] p3);
    logic [23:0] res;
    int s, v;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(p0[ch*8 +: 8]) + int'(p1[ch*8 +: 8]) + int'(p2[ch*8 +: 8]) + int'(p3[ch*8 +: 8]);
`ifdef FB_AVG_ROUND_EN
      v = (s + 2) / 4;
      if (v > 255) v = 255;
`else
      v = s / 4;
`endif
      res[ch*8 +: 8] = 8'(v);
    end
    return res;
  endfunction

  task automatic clear_queues();
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    done_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input logic [23:0] d, input bit hold);
    int n;
    n = 0;
    if (hung) return;
    if (!hold && ($urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("beat_accept", {31'b0, in_ready}, 32'd1);
      hung = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] psz, input logic [19:0] base);
    start = 1'b1;
    photo_size = psz;
    fb_base = base;
    @(negedge clk);
    start = 1'b0;
    photo_size = 2'($urandom);
    fb_base = 20'($urandom);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("ready_after_start", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("ready_idle", {31'b0, in_ready}, 32'd0);
  endtask

  // pat_index: size-10 beats carry their own index as data.
  task automatic run_frame(input logic [1:0] psz, input logic [19:0] base,
                           input bit hold, input bit mid_start, input bit pat_index);
    int eff, nbeats;
    logic [23:0] blk[4];
    logic [23:0] d;
    eff = (psz == 2'b00) ? 2 : int'(psz);
    nbeats = (eff == 3) ? 4 * FW : (eff == 1) ? FW / 4 : FW;
    clear_queues();
    if (hold) begin
      in_valid = 1'b1;
      in_data  = 24'hDEAD00;
    end
    start_frame(psz, base);
    for (int b = 0; b < nbeats; b++) begin
      if (pat_index)                  d = 24'(b);
      else if (eff == 3 && b < 4)     d = 24'h0A0A0A + 24'(b) * 24'h010101;
      else if (eff == 1 && b == 0)    d = 24'hFF0000;
      else                            d = 24'($urandom);
      send_beat(d, hold);
      if (eff == 2) begin
        exp_a.push_back(ref_addr(2, base, b));
        exp_d.push_back(d);
      end else if (eff == 3) begin
        blk[b % 4] = d;
        if (b % 4 == 3) begin
          exp_a.push_back(ref_addr(3, base, b / 4));
          exp_d.push_back(ref_avg(blk[0], blk[1], blk[2], blk[3]));
        end
      end else begin
        for (int q = 0; q < 4; q++) begin
          exp_a.push_back(ref_addr(1, base, 4 * b + q));
          exp_d.push_back(d);
        end
      end
      if (mid_start && b == FW / 2) begin
        start = 1'b1;
        photo_size = 2'b11;
        fb_base = ~base;
        @(negedge clk);
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_done();
    chk("write_count", 32'(got_a.size()), 32'(exp_a.size()));
    chk("done_count", 32'(done_cnt), 32'd1);
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk($sformatf("addr[%0d]", i), {12'b0, got_a[i]}, {12'b0, exp_a[i]});
      chk($sformatf("data[%0d]", i), {8'b0, got_d[i]}, {8'b0, exp_d[i]});
    end
  endtask

  initial begin
    logic [19:0] b;
    logic [19:0] b2;
    logic [23:0] blk4[4];

    repeat (3) @(negedge clk);
    chk("rst_wen_n", {31'b0, im_wen_n}, 32'd1);
    chk("rst_im_a", {12'b0, im_a}, 32'd0);
    chk("rst_im_d", {8'b0, im_d}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 24'h123456;
    repeat (3) @(negedge clk);
    chk("idle_no_ready", {31'b0, in_ready}, 32'd0);
    chk("idle_no_write", 32'(got_a.size()), 32'd0);
    in_valid = 1'b0;

    // Size 10, index pattern at 0x10000.
    run_frame(2'b10, 20'h10000, 1'b0, 1'b0, 1'b1);

    // Size 00 decodes as 256x256; base near the top wraps.
    run_frame(2'b00, 20'hFFFF0, 1'b0, 1'b0, 1'b0);
    if (got_a.size() > 16) chk("wrap_addr16", {12'b0, got_a[16]}, 32'h00000);

    // Size 11 downscale.
    b = 20'($urandom);
    run_frame(2'b11, b, 1'b0, 1'b0, 1'b0);
    if (got_d.size() > 0) begin
`ifdef FB_AVG_ROUND_EN
      chk("avg_first", {8'b0, got_d[0]}, 32'h0C0C0C);
`else
      chk("avg_first", {8'b0, got_d[0]}, 32'h0B0B0B);
`endif
    end

    // Size 01 upscale.
    b = 20'($urandom);
    run_frame(2'b01, b, 1'b0, 1'b0, 1'b0);
    if (got_a.size() > 3) begin
      chk("up_a0", {12'b0, got_a[0]}, {12'b0, b + 20'h00000});
      chk("up_a1", {12'b0, got_a[1]}, {12'b0, b + 20'h00001});
      chk("up_a2", {12'b0, got_a[2]}, {12'b0, b + 20'h00100});
      chk("up_a3", {12'b0, got_a[3]}, {12'b0, b + 20'h00101});
      chk("up_d3", {8'b0, got_d[3]}, 32'hFF0000);
    end

    // Reset after 3 of 4 size-11 beats.
    clear_queues();
    b = 20'($urandom);
    start_frame(2'b11, b);
    for (int i = 0; i < 3; i++) send_beat(24'($urandom), 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wen_n", {31'b0, im_wen_n}, 32'd1);
    chk("mid_rst_im_a", {12'b0, im_a}, 32'd0);
    chk("mid_rst_im_d", {8'b0, im_d}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    clear_queues();
    @(negedge clk);
    reset = 1'b0;
    b2 = 20'($urandom);
    start_frame(2'b11, b2);
    blk4[0] = 24'h102030; blk4[1] = 24'h405060; blk4[2] = 24'h708090; blk4[3] = 24'hA0B0C1;
    for (int i = 0; i < 4; i++) send_beat(blk4[i], 1'b0);
    for (int n = 0; n < 20 && got_a.size() == 0; n++) @(negedge clk);
    chk("post_rst_writes", 32'(got_a.size()), 32'd1);
    if (got_a.size() > 0) begin
      chk("post_rst_addr", {12'b0, got_a[0]}, {12'b0, b2});
      chk("post_rst_data", {8'b0, got_d[0]}, {8'b0, ref_avg(blk4[0], blk4[1], blk4[2], blk4[3])});
    end
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // in_valid held high throughout plus a start pulse mid-frame.
    b = 20'($urandom);
    run_frame(2'b10, b, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
